keypad_scan_scheduler: RTL
==========================

// Module: keypad_scan_scheduler
// PURPOSE
//   Scans a 4x4 active-low matrix keypad one row at a time, debounces full-matrix
//   snapshots and turns each debounced press into a 4-bit key code event.
//   Events are queued in a small FIFO behind a valid/ready handshake.
//   It sits between the keypad pins and the consumer logic, e.g. a dot-matrix
//   renderer or a command decoder.
// PARAMETERS
//   SCAN_DIV        250000  clock cycles each row is driven (row dwell time)
//   DEBOUNCE_SCANS  3       consecutive full frames needed to accept a press or release (>=1)
//   FIFO_DEPTH      4       event FIFO entries (power of 2, >=2)
// PORTS
//   clock      in   1  system clock; all logic is on posedge clock
//   reset      in   1  synchronous active-low reset
//   keypadCol  in   4  column sense, active low (0 = key closed on driven row)
//   keypadRow  out  4  row drive, one-hot active low
//   key_code   out  4  code at the FIFO head; valid only while key_valid=1
//   key_valid  out  1  FIFO not empty
//   key_ready  in   1  consumer accepts the head event when key_valid=1 and key_ready=1
//   key_held   out  1  1 while state is PRESSED or DEB_REL
//   overflow   out  1  sticky; set when a press is dropped because the FIFO is full
// BEHAVIOUR
//   Reset: keypadRow=4'b1110, key_code=0, key_valid=0, key_held=0, overflow=0.
//     Dwell counter, FIFO pointers and debounce counter are cleared; state=IDLE.
//   Scan: row sequence is 1110 -> 1101 -> 1011 -> 0111 -> 1110.
//     Row index r = 0..3 in that order.
//   Dwell counter runs 0..SCAN_DIV-1. keypadCol is sampled into a 16-bit snapshot
//     on the count==SCAN_DIV-1 cycle, and the row advances on that same edge.
//   Frame: one frame is 4*SCAN_DIV cycles and completes when row r=3 is sampled.
//     The FSM is evaluated once per frame, on the cycle after the r=3 sample.
//   Key code for (row r, column c), c=0..3 for col 1110, 1101, 1011, 0111:
//     r0: 7 4 1 0 | r1: 8 5 2 A | r2: 9 6 3 B | r3: C D E F
//   Frame classes:
//     NONE   = no bit low in the snapshot
//     SINGLE = exactly one bit low
//     MULTI  = two or more bits low
//   FSM (cand = candidate code, dcnt = debounce counter):
//     IDLE:     SINGLE -> cand=code, dcnt=1, DEB_PRESS. NONE/MULTI -> stay.
//     DEB_PRESS:
//       SINGLE with same code -> dcnt+1.
//       SINGLE with a different code -> cand=new code, dcnt=1.
//       NONE/MULTI -> IDLE.
//       When dcnt reaches DEBOUNCE_SCANS -> PRESSED and push cand.
//       DEBOUNCE_SCANS=1 means push on the first SINGLE frame.
//     PRESSED:
//       cand bit still low (other bits ignored) -> stay.
//       Otherwise -> DEB_REL with dcnt=1.
//     DEB_REL:
//       cand bit low again -> PRESSED, no new push.
//       Otherwise dcnt+1; when dcnt reaches DEBOUNCE_SCANS -> IDLE.
//   Exactly one push per accepted press. Holding a key never auto-repeats.
//   FIFO:
//     key_valid = !empty; key_code = head entry.
//     Pop happens on the edge where key_valid and key_ready are both 1.
//     Next entry is presented on the following cycle.
//     Push into a full FIFO with no pop in the same cycle: entry dropped, overflow=1.
//     Push and pop in the same cycle while full: both happen, overflow unchanged.
//     Push into an empty FIFO: key_valid=1 one cycle after the FSM evaluation edge.
//   Latency: press stable from the start of a frame -> key_valid rises
//     DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles later.
//   Reset mid-operation (any state, any count): all state returns to reset values.
//     Pending FIFO events are discarded.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; frame = 16 cycles)
//   1. Reset then idle -> keypadRow steps 1110,1101,1011,0111 every 4 clocks.
//      All outputs stay 0.
//   2. Hold col 1011 while row 1101 is driven for 3 frames, key_ready=1
//      -> one key_valid pulse with key_code=2 after frame 2; key_held=1.
//      Release -> key_held=0 after 2 NONE frames.
//   3. Bounce pattern: key 5 down 1 frame, up 1 frame, down 1 frame, up
//      -> no event, key_valid stays 0.
//   4. key_ready=0, press keys 1,2,3,4,5 in turn -> FIFO holds 1,2,3,4 and overflow=1.
//      Then key_ready=1 -> codes 1,2,3,4 pop in order and key_valid falls.
//   5. Keys 7 and F pressed together from IDLE -> no event.
//      Key 7 held and accepted, then F added -> no second event, key_held stays 1.
//   6. Reset pulsed during DEB_PRESS for key C -> no event.
//      keypadRow=1110 on the cycle after reset.

Source files
------------

// File: rtl/keypad_scan_scheduler.sv
// 4x4 active-low keypad scanner: row-by-row sampling, frame-level debounce FSM,
// and a small event FIFO presenting key codes behind a valid/ready handshake.
module keypad_scan_scheduler #(
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DS         = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
        logic [3:0] code;
        case (pos)
            4'd0:  code = 4'h7;
            4'd1:  code = 4'h4;
            4'd2:  code = 4'h1;
            4'd3:  code = 4'h0;
            4'd4:  code = 4'h8;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h2;
            4'd7:  code = 4'hA;
            4'd8:  code = 4'h9;
            4'd9:  code = 4'h6;
            4'd10: code = 4'h3;
            4'd11: code = 4'hB;
            4'd12: code = 4'hC;
            4'd13: code = 4'hD;
            4'd14: code = 4'hE;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    logic [CW-1:0] dwell;
    logic [1:0]    row_idx;
    logic [15:0]   snap;
    logic          frame_done;
    logic          dwell_end;

    assign dwell_end = (dwell == DWELL_LAST);
    assign keypadRow = ~(4'b0001 << row_idx);

    // Snapshot bit index is row*4 + column; frame_done marks the evaluation cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dwell      <= '0;
            row_idx    <= 2'd0;
            snap       <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= dwell_end && (row_idx == 2'd3);
            if (dwell_end) begin
                dwell                          <= '0;
                row_idx                        <= row_idx + 2'd1;
                snap[{row_idx, 2'b00} +: 4]    <= keypadCol;
            end else begin
                dwell <= dwell + CW'(1);
            end
        end
    end

    logic [15:0] low;
    logic        is_single;
    logic [3:0]  low_pos;

    always_comb begin
        low       = ~snap;
        is_single = (low != 16'd0) && ((low & (low - 16'd1)) == 16'd0);
        low_pos   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (low[i]) low_pos = 4'(i);
        end
    end

    state_t        state, state_next;
    logic [3:0]    cand, cand_next;
    logic [DW-1:0] dcnt, dcnt_next;
    logic          push;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cand  <= 4'd0;
            dcnt  <= '0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            dcnt  <= dcnt_next;
        end
    end

    // cand holds the matrix position, so a held key is tracked by its own bit.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        dcnt_next  = dcnt;
        push       = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_next = low_pos;
                        dcnt_next = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next = PRESSED;
                            push       = 1'b1;
                        end else begin
                            state_next = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!is_single) begin
                        state_next = IDLE;
                    end else begin
                        if (low_pos == cand) begin
                            dcnt_next = dcnt + DW'(1);
                        end else begin
                            cand_next = low_pos;
                            dcnt_next = DW'(1);
                        end
                        if (dcnt_next == DS) begin
                            state_next = PRESSED;
                            push       = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!low[cand]) begin
                        dcnt_next  = DW'(1);
                        state_next = (DEBOUNCE_SCANS == 1) ? IDLE : DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (low[cand]) begin
                        state_next = PRESSED;
                    end else begin
                        dcnt_next = dcnt + DW'(1);
                        if (dcnt_next == DS) state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign key_held = (state == PRESSED) || (state == DEB_REL);

    logic [3:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = key_valid && key_ready;
    assign do_push   = push && (!full || pop);
    assign key_valid = !empty;
    assign key_code  = empty ? 4'd0 : mem[rd_ptr[AW-1:0]];

    // A simultaneous pop frees the slot, so a push into a full FIFO is only lost without one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= pos_to_code(cand_next);
    end

endmodule
